// File: rtl/route_seq_ctrl_pkg.sv
// Shared types for the convolution read sequencer.
// Config bundle, FSM states and address type.
package route_pkg;

  localparam int ADDR_WIDTH = 8;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } route_state_e;

  typedef struct packed {
    addr_t i_start;
    addr_t i_size;
    addr_t o_size;
    addr_t k_size;
    addr_t stride;
    addr_t w_start;
    addr_t w_off;
  } route_cfg_t;

endpackage

// File: rtl/route_seq_ctrl_if.sv
// Config, handshake and SRAM read bus of the sequencer.
// slave = sequencer side, master = driver side.
interface route_if #(
  parameter int ADDR_WIDTH = 8
);

  logic                  i_reg_clear;
  logic                  i_route_en;
  logic                  i_ready;
  logic [ADDR_WIDTH-1:0] i_i_start_addr;
  logic [ADDR_WIDTH-1:0] i_i_size;
  logic [ADDR_WIDTH-1:0] i_o_size;
  logic [ADDR_WIDTH-1:0] i_k_size;
  logic [ADDR_WIDTH-1:0] i_stride;
  logic [ADDR_WIDTH-1:0] i_w_start_addr;
  logic [ADDR_WIDTH-1:0] i_w_addr_offset;
  logic                  o_i_read_en;
  logic [ADDR_WIDTH-1:0] o_i_addr;
  logic                  o_w_read_en;
  logic [ADDR_WIDTH-1:0] o_w_addr;
  logic                  o_tap_valid;
  logic                  o_tap_last;
  logic                  o_busy;
  logic                  o_done;

  modport slave (
    input  i_reg_clear, i_route_en, i_ready,
    input  i_i_start_addr, i_i_size, i_o_size,
    input  i_k_size, i_stride,
    input  i_w_start_addr, i_w_addr_offset,
    output o_i_read_en, o_i_addr,
    output o_w_read_en, o_w_addr,
    output o_tap_valid, o_tap_last,
    output o_busy, o_done
  );

  modport master (
    output i_reg_clear, i_route_en, i_ready,
    output i_i_start_addr, i_i_size, i_o_size,
    output i_k_size, i_stride,
    output i_w_start_addr, i_w_addr_offset,
    input  o_i_read_en, o_i_addr,
    input  o_w_read_en, o_w_addr,
    input  o_tap_valid, o_tap_last,
    input  o_busy, o_done
  );

endinterface

// File: rtl/route_seq_ctrl_win_addr_gen.sv
// Window walker: kx/ky/ox/oy counters and adder-only
// address pointers (output row, window, kernel row).
module win_addr_gen
  import route_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  route_cfg_t cfg,
  output addr_t      i_addr,
  output addr_t      w_addr,
  output logic       tap_last,
  output logic       run_last,
  output logic       step_ok
);

  addr_t kx, ky, ox, oy;
  addr_t orow, win, row;
  addr_t rstep, rcnt;
  logic  kx_end, ky_end, ox_end, oy_end, row_end;

  assign kx_end   = kx == cfg.k_size - 1'b1;
  assign ky_end   = ky == cfg.k_size - 1'b1;
  assign ox_end   = ox == cfg.o_size - 1'b1;
  assign oy_end   = oy == cfg.o_size - 1'b1;
  assign row_end  = kx_end && ky_end && ox_end;
  assign tap_last = kx_end && ky_end;
  assign run_last = row_end && oy_end;
  // rstep (stride*i_size) builds up by repeated adds;
  // only a move to the next output row must wait for it.
  assign step_ok  = rcnt == '0 || !row_end || oy_end;

  // Counter advance, kx fastest, with pointer updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kx     <= '0;
      ky     <= '0;
      ox     <= '0;
      oy     <= '0;
      orow   <= '0;
      win    <= '0;
      row    <= '0;
      i_addr <= '0;
      w_addr <= '0;
      rstep  <= '0;
      rcnt   <= '0;
    end else if (load) begin
      kx     <= '0;
      ky     <= '0;
      ox     <= '0;
      oy     <= '0;
      orow   <= cfg.i_start;
      win    <= cfg.i_start;
      row    <= cfg.i_start;
      i_addr <= cfg.i_start;
      w_addr <= cfg.w_start;
      rstep  <= '0;
      rcnt   <= cfg.stride;
    end else begin
      if (rcnt != '0) begin
        rstep <= rstep + cfg.i_size;
        rcnt  <= rcnt - 1'b1;
      end
      if (step) begin
        if (!kx_end) begin
          kx     <= kx + 1'b1;
          i_addr <= i_addr + 1'b1;
          w_addr <= w_addr + cfg.w_off;
        end else if (!ky_end) begin
          kx     <= '0;
          ky     <= ky + 1'b1;
          row    <= row + cfg.i_size;
          i_addr <= row + cfg.i_size;
          w_addr <= w_addr + cfg.w_off;
        end else if (!ox_end) begin
          kx     <= '0;
          ky     <= '0;
          ox     <= ox + 1'b1;
          win    <= win + cfg.stride;
          row    <= win + cfg.stride;
          i_addr <= win + cfg.stride;
          w_addr <= cfg.w_start;
        end else if (!oy_end) begin
          kx     <= '0;
          ky     <= '0;
          ox     <= '0;
          oy     <= oy + 1'b1;
          orow   <= orow + rstep;
          win    <= orow + rstep;
          row    <= orow + rstep;
          i_addr <= orow + rstep;
          w_addr <= cfg.w_start;
        end
      end
    end
  end

endmodule

// File: rtl/route_seq_ctrl.sv
// Convolution read-stream sequencer: FSM, config latch
// and the SRAM-latency valid/last delay line.
module route_seq_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int SRAM_LATENCY = 1
) (
  input logic   i_clk,
  input logic   i_nrst,
  route_if.slave bus
);

  import route_pkg::*;

  localparam int DW =
    (SRAM_LATENCY > 1) ? $clog2(SRAM_LATENCY) : 1;

  route_state_e            state;
  route_cfg_t              cfg_q, cfg_in, cfg_use;
  logic [DW-1:0]           drain_cnt;
  logic [SRAM_LATENCY-1:0] vld_pipe, last_pipe;
  addr_t                   i_addr, w_addr;
  logic                    tap_last, run_last;
  logic                    step_ok, strobe;

  assign cfg_in = '{
    i_start: bus.i_i_start_addr,
    i_size:  bus.i_i_size,
    o_size:  bus.i_o_size,
    k_size:  bus.i_k_size,
    stride:  bus.i_stride,
    w_start: bus.i_w_start_addr,
    w_off:   bus.i_w_addr_offset
  };

  // Live ports only while loading; latched copy afterwards.
  assign cfg_use = (state == LOAD) ? cfg_in : cfg_q;

  // Abort and reset both suppress the tap of that cycle.
  assign strobe = state == RUN && bus.i_ready && step_ok
               && i_nrst && !bus.i_reg_clear;

  win_addr_gen u_gen (
    .clk      (i_clk),
    .rst_n    (i_nrst),
    .load     (state == LOAD),
    .step     (strobe),
    .cfg      (cfg_use),
    .i_addr   (i_addr),
    .w_addr   (w_addr),
    .tap_last (tap_last),
    .run_last (run_last),
    .step_ok  (step_ok)
  );

  assign bus.o_i_read_en = strobe;
  assign bus.o_w_read_en = strobe;
  assign bus.o_i_addr    = i_addr;
  assign bus.o_w_addr    = w_addr;
  assign bus.o_tap_valid = vld_pipe[SRAM_LATENCY-1];
  assign bus.o_tap_last  = last_pipe[SRAM_LATENCY-1];
  assign bus.o_busy      = state inside {LOAD, RUN, DRAIN};
  assign bus.o_done      = state == DONE;

  // Run control, config latch and tap delay line.
  always_ff @(posedge i_clk) begin
    if (!i_nrst || bus.i_reg_clear) begin
      state     <= IDLE;
      drain_cnt <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      if (!i_nrst) cfg_q <= '0;
    end else begin
      vld_pipe  <= SRAM_LATENCY'({vld_pipe, strobe});
      last_pipe <= SRAM_LATENCY'({last_pipe,
                                  strobe && tap_last});
      unique case (state)
        IDLE: if (bus.i_route_en) state <= LOAD;
        LOAD: begin
          cfg_q <= cfg_in;
          if (cfg_in.o_size == '0 || cfg_in.k_size == '0)
            state <= DONE;
          else
            state <= RUN;
        end
        RUN: if (strobe && run_last) begin
          state     <= DRAIN;
          drain_cnt <= DW'(SRAM_LATENCY - 1);
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= DONE;
          else drain_cnt <= drain_cnt - 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/route_seq_ctrl.md
Name: route_seq_ctrl

Overview:
- Sequencer for the router's convolution read stream: on i_route_en it walks output pixels row-major and, for each, the KxK kernel window row-major.
- Per tap it issues one input-SRAM read and one weight-SRAM read, then presents a tagged, 1-cycle-delayed valid to the router.
- Sits between configuration registers and the router/SRAM read ports; one element per SRAM address.

Parameters:
- ADDR_WIDTH, 8, width of all address and size fields
- SRAM_LATENCY, 1, SRAM read latency in cycles; sets the o_tap_valid delay

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  synchronous active-low reset
- i_reg_clear  in  1  synchronous abort to IDLE
- i_route_en  in  1  start request, level, sampled in IDLE only
- i_ready  in  1  router can accept a tap this cycle
- i_i_start_addr  in  ADDR_WIDTH  input feature-map base
- i_i_size  in  ADDR_WIDTH  input row width/height
- i_o_size  in  ADDR_WIDTH  output width/height
- i_k_size  in  ADDR_WIDTH  kernel width/height
- i_stride  in  ADDR_WIDTH  window step
- i_w_start_addr  in  ADDR_WIDTH  weight base
- i_w_addr_offset  in  ADDR_WIDTH  weight address step per tap
- o_i_read_en  out  1  input-SRAM read strobe
- o_i_addr  out  ADDR_WIDTH  input-SRAM read address
- o_w_read_en  out  1  weight-SRAM read strobe; equals o_i_read_en
- o_w_addr  out  ADDR_WIDTH  weight-SRAM read address
- o_tap_valid  out  1  SRAM data for a tap is valid this cycle
- o_tap_last  out  1  with o_tap_valid: last tap of the window
- o_busy  out  1  high from LOAD through DRAIN
- o_done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (i_nrst=0 at edge): state IDLE; all outputs 0; counters and pipeline cleared. Reset mid-run discards all in-flight taps.
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE -> LOAD when i_route_en=1. Config ports are latched in LOAD; later config changes are ignored until next run.
- LOAD -> DONE if o_size==0 or k_size==0 (no reads issued); otherwise LOAD -> RUN. Counters are zeroed in LOAD.
- RUN issues one tap per cycle when i_ready=1: o_i_read_en = o_w_read_en = 1.
  - o_i_addr = start + (oy*stride+ky)*i_size + ox*stride + kx
  - o_w_addr = w_start + (ky*k+kx)*w_addr_offset
- i_ready=0: no strobes, and counters and addresses hold.
- Address arithmetic: incremental adders only, no multipliers. Keep a window-base pointer and a row pointer; all sums are modulo 2^ADDR_WIDTH (silent wrap).
- Counter order: kx fastest, then ky, ox, oy. The weight address restarts at w_start at each new window.
- RUN -> DRAIN after the tap (oy,ox,ky,kx) = (o-1,o-1,k-1,k-1) issues.
- DRAIN lasts SRAM_LATENCY cycles, then DONE. DONE pulses o_done for 1 cycle, then IDLE.
- A new run requires i_route_en sampled again in IDLE; holding it high restarts immediately.
- o_tap_valid / o_tap_last are the read strobe and the kx==k-1 && ky==k-1 flag, delayed SRAM_LATENCY cycles through a shift pipeline. There is no stall of the pipeline; the router must accept any tap it requested.
- o_busy = 1 in LOAD, RUN, DRAIN.
- i_reg_clear=1 in any state: next state IDLE, strobes 0, pipeline flushed, no o_done. If asserted with i_route_en, clear wins.
- Total taps per run = o_size^2 * k_size^2. Counts use 2*ADDR_WIDTH internally where the product can overflow.

Decomposition:
- Package route_pkg: state enum route_state_e {IDLE, LOAD, RUN, DRAIN, DONE}, ADDR_WIDTH default, config struct route_cfg_t holding all latched config fields.
- One sub-module: win_addr_gen. It holds the kx/ky/ox/oy counters and the incremental address pointers, advances on a step enable, and flags tap_last/run_last.
- The FSM and latency pipeline stay in route_seq_ctrl.

Test Plan:
- Basic 3x3 window: i_size=5, o_size=3, k=3, stride=1, start=0, w_start=0, offset=1, i_ready=1.
  - Window 0 input addrs 0,1,2,5,6,7,10,11,12; window 1 begins 1,2,3,6,…
  - Last window begins 12 and ends 24; weight addrs 0..8 repeat.
  - 81 strobes, 9 o_tap_last, o_done exactly once, 1 cycle after the last o_tap_valid.
- Stride 2: i_size=5, o_size=2, k=3. Windows start at 0, 2, 10, 12; 36 taps.
- Backpressure: i_ready toggles 1,0,0,1 during window 0 -> no strobe while low, address held, sequence identical to the basic case; total taps still 81.
- Degenerate: o_size=0 -> LOAD, DONE, o_done pulse, zero strobes, o_busy high exactly 1 cycle.
- Abort and reset: i_reg_clear during tap 20 -> next cycle IDLE, no further o_tap_valid after the flush, no o_done. Same run with i_nrst=0 instead gives identical result; a fresh start afterwards reproduces the basic sequence.
- Wrap: start=250, i_size=5, o_size=1, k=3. Addresses 250,251,252,255,0,1,4,5,6 (mod 256).
